aes_ctr_stream: RTL and testbench
=================================

AES_CTR_STREAM -- requirements
Module: aes_ctr_stream

Interface
REQ-001 SHALL have parameter LATENCY, default 11: cycles from registered counter into the AES_pipeline_Encryption core until its cypher output.
REQ-002 SHALL have parameter CTR_WIDTH, default 32: number of low counter-block bits that increment; range 1..128.
REQ-003 SHALL have parameter FIFO_DEPTH, default 16: output FIFO entries; FIFO_DEPTH >= LATENCY+2 is required.
REQ-004 SHALL have port clk, input, 1: clock; all logic rising-edge.
REQ-005 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-006 SHALL have port start, input, 1: single-cycle request to begin a message.
REQ-007 SHALL have port key, input, 128: AES key, sampled on an accepted start.
REQ-008 SHALL have port iv, input, 128: initial counter block, sampled on an accepted start.
REQ-009 SHALL have port s_valid, input, 1: plaintext beat valid.
REQ-010 SHALL have port s_ready, output, 1: plaintext beat accepted when s_valid && s_ready.
REQ-011 SHALL have port s_data, input, 128: plaintext block.
REQ-012 SHALL have port s_last, input, 1: final beat of the message.
REQ-013 SHALL have port m_valid, output, 1: ciphertext beat valid.
REQ-014 SHALL have port m_ready, input, 1: downstream accepts when m_valid && m_ready.
REQ-015 SHALL have port m_data, output, 128: ciphertext block.
REQ-016 SHALL have port m_last, output, 1: s_last carried with the beat.
REQ-017 SHALL have port busy, output, 1: state is not IDLE.
REQ-018 SHALL have port done, output, 1: one-cycle pulse when the message fully drains.
REQ-019 SHALL have port ctr_wrap, output, 1: sticky flag set when the low CTR_WIDTH counter bits wrap.

Function
REQ-020 SHALL implement FSM IDLE -> RUN on start in IDLE, RUN -> DRAIN on an accepted beat with s_last=1, DRAIN -> IDLE when nothing is in flight and the FIFO is empty.
REQ-021 SHALL ignore start outside IDLE.
REQ-022 SHALL, on start, load key_q <= key, ctr <= iv, and clear ctr_wrap; key_q SHALL stay constant until the next accepted start.
REQ-023 SHALL drive s_ready = (state==RUN) && (fifo_count + inflight < FIFO_DEPTH), using registered counts with no same-cycle pop credit.
REQ-024 SHALL, on each accepted beat, present ctr to the core and then set ctr[CTR_WIDTH-1:0] <= ctr[CTR_WIDTH-1:0]+1 mod 2^CTR_WIDTH, leaving the upper bits unchanged.
REQ-025 SHALL set ctr_wrap when the increment takes the low bits from all-ones to zero, and keep it set until the next start or reset.
REQ-026 SHALL delay s_data, s_last and a valid bit by exactly the core latency, in lockstep with the counter.
REQ-027 SHALL, for a beat accepted at edge k, write s_data ^ keystream into the FIFO at edge k+LATENCY+1.
REQ-028 SHALL, when the FIFO is empty at that point, assert m_valid with that beat from edge k+LATENCY+1.
REQ-029 SHALL keep the in-flight count equal to the number of set valid-pipeline bits, ranging 0..LATENCY+1.
REQ-030 SHALL treat a simultaneous FIFO push and pop as count unchanged, and SHALL never overflow the FIFO because of REQ-023.
REQ-031 SHALL hold m_data and m_last stable while m_valid && !m_ready, with beats emitted in acceptance order.
REQ-032 SHALL pulse done for exactly one cycle on the DRAIN -> IDLE transition.
REQ-033 SHALL treat an accepted s_last beat while the FIFO is full-credit as normal, i.e. DRAIN waits for all beats to pop.

Reset
REQ-034 SHALL, while reset is asserted at any time, force state IDLE and s_ready=0, m_valid=0, m_data=0, m_last=0, busy=0, done=0, ctr_wrap=0.
REQ-035 SHALL, while reset is asserted, clear ctr and key_q, empty the FIFO and clear all pipeline valid bits.
REQ-036 SHALL discard any beats in flight when reset is asserted mid-message.

Verification
REQ-037 SHALL cover SP800-38A F.5.1: key 2b7e151628aed2a6abf7158809cf4f3c, iv f0f1f2f3f4f5f6f7f8f9fafbfcfdfeff, pt 6bc1bee22e409f96e93d7e117393172a, ae2d8a571e03ac9c9eb76fac45af8e51 (last) -> ct 874d6191b620e3261bef6864990db6ce, 9806f66b7970fdff8617187bb9fffdff, m_last on the second beat, done once.
REQ-038 SHALL cover latency: single beat accepted at edge k with m_ready=1 -> m_valid first high after edge k+12 (LATENCY=11).
REQ-039 SHALL cover backpressure: m_ready=0 with s_valid=1 continuous -> s_ready drops after 16 accepts, no beat lost, m_data stable; releasing m_ready -> all 16 beats emerge in order.
REQ-040 SHALL cover wrap: iv low 32 bits ffffffff, two beats -> second counter block has low bits 00000000 and upper 96 bits unchanged, ctr_wrap=1, cleared by the next start.
REQ-041 SHALL cover reset mid-message: reset after 5 beats accepted and 3 output -> no further m_valid, busy=0; a new message after reset matches REQ-037 vectors.
REQ-042 SHALL cover start while busy: no effect on key_q, ctr or ciphertext.

Source files
------------

// File: rtl/aes_ctr_stream.sv
// +----------------------------------------------------------------------------+
// | aes_ctr_stream: AES-128 counter-mode stream cipher over a valid/ready beat  |
// | stream, with a fully pipelined core and a credit-guarded output FIFO.       |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
`default_nettype none

module aes_ctr_stream #(
  parameter int LATENCY    = 11,
  parameter int CTR_WIDTH  = 32,
  parameter int FIFO_DEPTH = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [127:0] key,
  input  logic [127:0] iv,
  input  logic         s_valid,
  output logic         s_ready,
  input  logic [127:0] s_data,
  input  logic         s_last,
  output logic         m_valid,
  input  logic         m_ready,
  output logic [127:0] m_data,
  output logic         m_last,
  output logic         busy,
  output logic         done,
  output logic         ctr_wrap
);

  localparam int c_if_w  = $clog2(LATENCY + 2);
  localparam int c_cnt_w = $clog2(FIFO_DEPTH + 1);
  localparam int c_ptr_w = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [127:0] c_ctr_mask = {128{1'b1}} >> (128 - CTR_WIDTH);

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = xt(aa);
    end
    return p;
  endfunction

  // S-box as GF(2^8) inverse (x^254) followed by the affine transform.
  function automatic logic [7:0] sbox(input logic [7:0] b);
    logic [7:0] x3, x7, x15, x31, x63, x127, inv;
    x3   = gmul(gmul(b, b), b);
    x7   = gmul(gmul(x3, x3), b);
    x15  = gmul(gmul(x7, x7), b);
    x31  = gmul(gmul(x15, x15), b);
    x63  = gmul(gmul(x31, x31), b);
    x127 = gmul(gmul(x63, x63), b);
    inv  = gmul(x127, x127);
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] rcon(input int n);
    logic [7:0] r;
    r = 8'h01;
    for (int j = 1; j < n; j++) r = xt(r);
    return r;
  endfunction

  function automatic logic [127:0] key_expand(input logic [127:0] k, input int n);
    logic [31:0] w0, w1, w2, w3, t;
    {w0, w1, w2, w3} = k;
    t  = {sbox(w3[23:16]), sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])} ^ {rcon(n), 24'h0};
    w0 = w0 ^ t;
    w1 = w1 ^ w0;
    w2 = w2 ^ w1;
    w3 = w3 ^ w2;
    return {w0, w1, w2, w3};
  endfunction

  function automatic logic [127:0] aes_round(input logic [127:0] st, input logic [127:0] rk,
                                             input logic fin);
    logic [7:0]   sr [16];
    logic [7:0]   a0, a1, a2, a3;
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        sr[r + 4*c] = sbox(st[127 - 8*(r + 4*((c + r) % 4)) -: 8]);
    for (int c = 0; c < 4; c++) begin
      a0 = sr[4*c]; a1 = sr[4*c + 1]; a2 = sr[4*c + 2]; a3 = sr[4*c + 3];
      if (fin) o[127 - 32*c -: 32] = {a0, a1, a2, a3};
      else     o[127 - 32*c -: 32] = {xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3,
                                      a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3,
                                      a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3,
                                      xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3)};
    end
    return o ^ rk;
  endfunction

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2} state_t;

  state_t             r_state, w_state_nxt;
  logic [127:0]       r_key, r_ctr, w_ctr_inc;
  logic               r_ctr_wrap;
  logic [LATENCY:0]   r_vld, r_last;
  logic [127:0]       r_st   [0:LATENCY];
  logic [127:0]       r_rk   [0:LATENCY];
  logic [127:0]       w_rk   [0:LATENCY];
  logic [127:0]       r_data [0:LATENCY];
  logic [c_if_w-1:0]  r_inflight;
  logic [c_cnt_w-1:0] r_fifo_count;
  logic [c_ptr_w-1:0] r_wr_ptr, r_rd_ptr;
  logic [128:0]       r_mem [0:FIFO_DEPTH-1];
  logic               w_accept, w_push, w_pop;

  // Credit check uses registered counts only, so a pop this cycle frees no slot yet.
  assign s_ready   = (r_state == RUN) &&
                     ((32'(r_fifo_count) + 32'(r_inflight)) < 32'(FIFO_DEPTH));
  assign w_accept  = s_valid && s_ready;
  assign w_push    = r_vld[LATENCY];
  assign w_pop     = m_valid && m_ready;
  assign m_valid   = (r_fifo_count != '0);
  assign m_data    = m_valid ? r_mem[r_rd_ptr][127:0] : '0;
  assign m_last    = m_valid ? r_mem[r_rd_ptr][128] : 1'b0;
  assign busy      = (r_state != IDLE);
  assign ctr_wrap  = r_ctr_wrap;
  assign w_ctr_inc = (r_ctr & ~c_ctr_mask) | ((r_ctr + 128'd1) & c_ctr_mask);

  always_comb begin
    w_state_nxt = r_state;
    done        = 1'b0;
    case (r_state)
      IDLE:    if (start) w_state_nxt = RUN;
      RUN:     if (w_accept && s_last) w_state_nxt = DRAIN;
      DRAIN: begin
        if (r_fifo_count == '0 && r_inflight == '0) begin
          w_state_nxt = IDLE;
          done        = 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= IDLE;
      r_key        <= '0;
      r_ctr        <= '0;
      r_ctr_wrap   <= 1'b0;
      r_vld        <= '0;
      r_inflight   <= '0;
      r_fifo_count <= '0;
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == IDLE && start) begin
        r_key      <= key;
        r_ctr      <= iv;
        r_ctr_wrap <= 1'b0;
      end else if (w_accept) begin
        r_ctr <= w_ctr_inc;
        if ((r_ctr & c_ctr_mask) == c_ctr_mask) r_ctr_wrap <= 1'b1;
      end
      r_vld        <= {r_vld[LATENCY-1:0], w_accept};
      r_inflight   <= r_inflight + c_if_w'(w_accept) - c_if_w'(w_push);
      r_fifo_count <= r_fifo_count + c_cnt_w'(w_push) - c_cnt_w'(w_pop);
      if (w_push)
        r_wr_ptr <= (r_wr_ptr == c_ptr_w'(FIFO_DEPTH - 1)) ? '0 : r_wr_ptr + c_ptr_w'(1);
      if (w_pop)
        r_rd_ptr <= (r_rd_ptr == c_ptr_w'(FIFO_DEPTH - 1)) ? '0 : r_rd_ptr + c_ptr_w'(1);
    end
  end

  // Round keys are expanded on the fly, each stage carrying its own key forward.
  always_comb begin
    for (int i = 0; i <= LATENCY; i++) w_rk[i] = '0;
    for (int i = 1; i <= LATENCY; i++)
      if (i <= 10) w_rk[i] = key_expand(r_rk[i-1], i);
  end

  // Stage 0 is the initial AddRoundKey, stages 1..10 the rounds, the rest pure delay.
  always_ff @(posedge clk) begin
    r_st[0]   <= r_ctr ^ r_key;
    r_rk[0]   <= r_key;
    r_data[0] <= s_data;
    r_last[0] <= s_last;
    for (int i = 1; i <= LATENCY; i++) begin
      r_data[i] <= r_data[i-1];
      r_last[i] <= r_last[i-1];
      if (i <= 10) begin
        r_st[i] <= aes_round(r_st[i-1], w_rk[i], (i == 10));
        r_rk[i] <= w_rk[i];
      end else begin
        r_st[i] <= r_st[i-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= {r_last[LATENCY], r_st[LATENCY] ^ r_data[LATENCY]};
  end

endmodule

`default_nettype wire

// File: tb/tb_aes_ctr_stream.sv
// Directed bench for aes_ctr_stream using the SP800-38A CTR-AES128 vectors.
`timescale 1ns/1ps
`default_nettype none

module tb_aes_ctr_stream;

  localparam logic [127:0] K   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] IV  = 128'hf0f1f2f3f4f5f6f7f8f9fafbfcfdfeff;
  localparam logic [127:0] IVW = 128'hf0f1f2f3f4f5f6f7f8f9fafbffffffff;
  localparam logic [127:0] P1  = 128'h6bc1bee22e409f96e93d7e117393172a;
  localparam logic [127:0] P2  = 128'hae2d8a571e03ac9c9eb76fac45af8e51;
  localparam logic [127:0] P3  = 128'h30c81c46a35ce411e5fbc1191a0a52ef;
  localparam logic [127:0] P4  = 128'hf69f2445df4f9b17ad2b417be66c3710;
  localparam logic [127:0] C1  = 128'h874d6191b620e3261bef6864990db6ce;
  localparam logic [127:0] C2  = 128'h9806f66b7970fdff8617187bb9fffdff;
  localparam logic [127:0] C3  = 128'h5ae4df3edbd5d35e5b4f09020db03eab;
  localparam logic [127:0] C4  = 128'h1e031dda2fbe03d1792170a0f3009cee;

  logic         clk = 1'b0;
  logic         reset, start, s_valid, s_ready, s_last, m_valid, m_ready, m_last;
  logic         busy, done, ctr_wrap;
  logic [127:0] key, iv, s_data, m_data;

  int           checks = 0;
  int           passed = 0;
  int           done_cnt = 0;
  logic [128:0] outq [$];

  always #5 clk = ~clk;

  aes_ctr_stream dut (
    .clk(clk), .reset(reset), .start(start), .key(key), .iv(iv),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
    .busy(busy), .done(done), .ctr_wrap(ctr_wrap)
  );

  // Inputs change on negedge; 2ns later the handshake seen here is what the next posedge takes.
  always @(negedge clk) begin
    #2;
    if (m_valid && m_ready) outq.push_back({m_last, m_data});
    if (done) done_cnt++;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  function automatic logic [127:0] bp_pt(input int i);
    logic [31:0] w;
    w = i;
    case (i)
      0:       return P1;
      1:       return P2;
      2:       return P3;
      3:       return P4;
      default: return {w, w, w, w};
    endcase
  endfunction

  task automatic do_start(input logic [127:0] k, input logic [127:0] v);
    key = k; iv = v; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send_beat(input logic [127:0] d, input logic l, output bit ok);
    s_valid = 1'b1; s_data = d; s_last = l; ok = 1'b0;
    for (int n = 0; n < 200 && !ok; n++) begin
      #1;
      ok = s_ready;
      @(negedge clk);
    end
    s_valid = 1'b0; s_last = 1'b0;
  endtask

  task automatic wait_idle(output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 400; n++) begin
      if (!busy) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++; if (s_ready !== 1'b0) $display("FAIL rst_s_ready: got %b want 0", s_ready); else passed++;
    checks++; if (m_valid !== 1'b0) $display("FAIL rst_m_valid: got %b want 0", m_valid); else passed++;
    checks++; if (m_data !== 128'h0) $display("FAIL rst_m_data: got %h want 0", m_data); else passed++;
    checks++; if (m_last !== 1'b0) $display("FAIL rst_m_last: got %b want 0", m_last); else passed++;
    checks++; if (busy !== 1'b0) $display("FAIL rst_busy: got %b want 0", busy); else passed++;
    checks++; if (done !== 1'b0) $display("FAIL rst_done: got %b want 0", done); else passed++;
    checks++; if (ctr_wrap !== 1'b0) $display("FAIL rst_ctr_wrap: got %b want 0", ctr_wrap); else passed++;
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_f51();
    bit ok1, ok2, ok3;
    outq.delete(); done_cnt = 0; m_ready = 1'b1;
    do_start(K, IV);
    checks++; if (busy !== 1'b1) $display("FAIL f51_busy: got %b want 1", busy); else passed++;
    send_beat(P1, 1'b0, ok1);
    send_beat(P2, 1'b1, ok2);
    wait_idle(ok3);
    checks++; if (!(ok1 && ok2 && ok3)) $display("FAIL f51_timeout: got %b%b%b want 111", ok1, ok2, ok3); else passed++;
    checks++; if (outq.size() != 2) $display("FAIL f51_count: got %0d want 2", outq.size()); else passed++;
    checks++; if (outq.size() < 1 || outq[0] !== {1'b0, C1}) $display("FAIL f51_beat0: got %h want %h", outq[0], {1'b0, C1}); else passed++;
    checks++; if (outq.size() < 2 || outq[1] !== {1'b1, C2}) $display("FAIL f51_beat1: got %h want %h", outq[1], {1'b1, C2}); else passed++;
    checks++; if (done_cnt != 1) $display("FAIL f51_done: got %0d want 1", done_cnt); else passed++;
  endtask

  task automatic test_latency();
    bit ok1, ok2;
    int first;
    outq.delete(); done_cnt = 0; m_ready = 1'b1; first = -1;
    do_start(K, IV);
    send_beat(P1, 1'b1, ok1);
    for (int j = 0; j < 30; j++) begin
      if (m_valid && first < 0) first = j;
      @(negedge clk);
    end
    wait_idle(ok2);
    checks++; if (!(ok1 && ok2) || first != 12) $display("FAIL latency: got %0d edges want 12", first); else passed++;
    checks++; if (outq.size() != 1 || outq[0] !== {1'b1, C1}) $display("FAIL latency_data: got %h want %h", outq[0], {1'b1, C1}); else passed++;
  endtask

  task automatic test_backpressure();
    bit ok1, ok2;
    int acc, nlast;
    logic [127:0] held;
    outq.delete(); m_ready = 1'b0; acc = 0;
    do_start(K, IV);
    s_valid = 1'b1; s_last = 1'b0; s_data = bp_pt(0);
    for (int n = 0; n < 40; n++) begin
      #1;
      if (s_ready) acc++;
      @(negedge clk);
      s_data = bp_pt(acc);
    end
    checks++; if (acc != 16) $display("FAIL bp_accepts: got %0d want 16", acc); else passed++;
    checks++; if (s_ready !== 1'b0) $display("FAIL bp_s_ready: got %b want 0", s_ready); else passed++;
    checks++; if (m_valid !== 1'b1 || m_data !== C1) $display("FAIL bp_head: got %b/%h want 1/%h", m_valid, m_data, C1); else passed++;
    held = m_data;
    repeat (5) @(negedge clk);
    checks++; if (m_data !== held || m_valid !== 1'b1) $display("FAIL bp_stable: got %h want %h", m_data, held); else passed++;
    m_ready = 1'b1;
    send_beat(bp_pt(16), 1'b1, ok1);
    wait_idle(ok2);
    checks++; if (!(ok1 && ok2) || outq.size() != 17) $display("FAIL bp_count: got %0d want 17", outq.size()); else passed++;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (outq.size() <= i || outq[i][127:0] !== (i == 0 ? C1 : i == 1 ? C2 : i == 2 ? C3 : C4))
        $display("FAIL bp_order%0d: got %h", i, outq[i]);
      else passed++;
    end
    nlast = 0;
    foreach (outq[i]) if (outq[i][128]) nlast++;
    checks++; if (nlast != 1 || outq[outq.size()-1][128] !== 1'b1) $display("FAIL bp_last: got %0d lasts want 1 at end", nlast); else passed++;
  endtask

  task automatic test_wrap();
    bit ok1, ok2, ok3;
    outq.delete(); done_cnt = 0; m_ready = 1'b1;
    do_start(K, IVW);
    checks++; if (ctr_wrap !== 1'b0 || dut.r_ctr !== IVW) $display("FAIL wrap_load: got %b/%h want 0/%h", ctr_wrap, dut.r_ctr, IVW); else passed++;
    send_beat(P1, 1'b0, ok1);
    checks++; if (ctr_wrap !== 1'b1) $display("FAIL wrap_flag: got %b want 1", ctr_wrap); else passed++;
    checks++; if (dut.r_ctr !== {IVW[127:32], 32'h0}) $display("FAIL wrap_ctr: got %h want %h", dut.r_ctr, {IVW[127:32], 32'h0}); else passed++;
    send_beat(P2, 1'b1, ok2);
    wait_idle(ok3);
    checks++; if (!(ok1 && ok2 && ok3) || ctr_wrap !== 1'b1 || done_cnt != 1) $display("FAIL wrap_sticky: got %b done=%0d want 1/1", ctr_wrap, done_cnt); else passed++;
    outq.delete();
    do_start(K, IV);
    checks++; if (ctr_wrap !== 1'b0) $display("FAIL wrap_clear: got %b want 0", ctr_wrap); else passed++;
    send_beat(P1, 1'b1, ok1);
    wait_idle(ok2);
    checks++; if (outq.size() != 1 || outq[0] !== {1'b1, C1}) $display("FAIL wrap_restart: got %h want %h", outq[0], {1'b1, C1}); else passed++;
  endtask

  task automatic test_reset_mid();
    bit ok;
    outq.delete(); m_ready = 1'b0;
    do_start(K, IV);
    for (int i = 0; i < 5; i++) send_beat(bp_pt(i), 1'b0, ok);
    repeat (16) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      m_ready = 1'b1;
      @(negedge clk);
    end
    m_ready = 1'b0;
    checks++; if (outq.size() != 3 || outq[2] !== {1'b0, C3}) $display("FAIL rmid_pre: got %0d beats, last %h want 3, %h", outq.size(), outq[2], {1'b0, C3}); else passed++;
    reset = 1'b1;
    #1;
    checks++; if (m_valid !== 1'b0 || busy !== 1'b0) $display("FAIL rmid_reset: got valid=%b busy=%b want 0/0", m_valid, busy); else passed++;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0; m_ready = 1'b1;
    repeat (20) @(negedge clk);
    checks++; if (outq.size() != 3 || busy !== 1'b0) $display("FAIL rmid_flush: got %0d beats busy=%b want 3/0", outq.size(), busy); else passed++;
    outq.delete(); done_cnt = 0;
    do_start(K, IV);
    send_beat(P1, 1'b0, ok);
    send_beat(P2, 1'b1, ok);
    wait_idle(ok);
    checks++; if (outq.size() != 2 || outq[0] !== {1'b0, C1} || outq[1] !== {1'b1, C2}) $display("FAIL rmid_after: got %h %h want %h %h", outq[0], outq[1], {1'b0, C1}, {1'b1, C2}); else passed++;
    checks++; if (done_cnt != 1) $display("FAIL rmid_done: got %0d want 1", done_cnt); else passed++;
  endtask

  task automatic test_start_busy();
    bit ok1, ok2, ok3;
    outq.delete(); done_cnt = 0; m_ready = 1'b1;
    do_start(K, IV);
    send_beat(P1, 1'b0, ok1);
    do_start({128{1'b1}}, 128'h0123456789abcdef0123456789abcdef);
    send_beat(P2, 1'b1, ok2);
    do_start(128'h0, 128'h0);
    wait_idle(ok3);
    checks++; if (!(ok1 && ok2 && ok3) || outq.size() != 2) $display("FAIL busy_count: got %0d want 2", outq.size()); else passed++;
    checks++; if (outq[0] !== {1'b0, C1} || outq[1] !== {1'b1, C2}) $display("FAIL busy_data: got %h %h want %h %h", outq[0], outq[1], {1'b0, C1}, {1'b1, C2}); else passed++;
    checks++; if (dut.r_key !== K || done_cnt != 1) $display("FAIL busy_key: got %h done=%0d want %h/1", dut.r_key, done_cnt, K); else passed++;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; key = '0; iv = '0;
    s_valid = 1'b0; s_data = '0; s_last = 1'b0; m_ready = 1'b0;
    test_reset();
    test_f51();
    test_latency();
    test_backpressure();
    test_wrap();
    test_reset_mid();
    test_start_busy();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

`default_nettype wire
